cnt60_timer_ctrl: RTL and testbench

Run/stop/alarm controller that sequences the CNT60 seconds-counter datapath. It debounces four front-panel buttons and generates the 1-second step tick. It drives the counter's enable, direction and clear inputs, and raises an alarm when a countdown reaches 00. It sits between the board buttons and the CNT60 counter/7-segment block.

---
 rtl/cnt60_ctrl_pkg.sv | 25 ++
 rtl/btn_debounce.sv | 45 ++++
 rtl/cnt60_timer_ctrl.sv | 141 ++++++++++++++
 tb/tb_cnt60_timer_ctrl.sv | 321 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cnt60_ctrl_pkg.sv
// Shared definitions for the CNT60 run/stop/alarm controller: state encoding,
// button priority order and the priority-pick helper.
package cnt60_ctrl_pkg;

  localparam int STATE_W = 3;

  typedef enum logic [STATE_W-1:0] {
    ST_IDLE  = 3'd0,
    ST_RUN   = 3'd1,
    ST_PAUSE = 3'd2,
    ST_ALARM = 3'd3
  } state_e;

  // Bit positions in the press vector; a lower index wins on a same-cycle tie.
  localparam int NUM_BTN  = 4;
  localparam int IDX_CLR  = 0;
  localparam int IDX_SS   = 1;
  localparam int IDX_MODE = 2;
  localparam int IDX_INC  = 3;

  function automatic logic [NUM_BTN-1:0] prio_pick(input logic [NUM_BTN-1:0] p);
    return p & (~p + NUM_BTN'(1));
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// Single-button conditioner: 2-FF synchronizer, stability counter and a
// one-cycle registered pulse on each debounced press (0->1) edge.
module btn_debounce #(
  parameter int DEB_MAX = 1_000_000
) (
  input  logic CLK,
  input  logic RESET,
  input  logic BTN,
  output logic PRESS
);

  localparam int CW = (DEB_MAX > 1) ? $clog2(DEB_MAX) : 1;

  logic          sync1;
  logic          sync2;
  logic          level;
  logic          level_d;
  logic [CW-1:0] stable_cnt;

  // The level only moves after DEB_MAX consecutive disagreeing samples.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      sync1      <= 1'b0;
      sync2      <= 1'b0;
      level      <= 1'b0;
      level_d    <= 1'b0;
      stable_cnt <= '0;
      PRESS      <= 1'b0;
    end else begin
      sync1   <= BTN;
      sync2   <= sync1;
      level_d <= level;
      PRESS   <= level & ~level_d;
      if (sync2 == level) begin
        stable_cnt <= '0;
      end else if (stable_cnt == CW'(DEB_MAX - 1)) begin
        level      <= sync2;
        stable_cnt <= '0;
      end else begin
        stable_cnt <= stable_cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/cnt60_timer_ctrl.sv
// Run/stop/alarm sequencer for the CNT60 seconds counter: button conditioning,
// 1-second prescaler, alarm timeout and registered counter control outputs.
module cnt60_timer_ctrl
  import cnt60_ctrl_pkg::*;
#(
  parameter int SEC1_MAX  = 100_000_000,
  parameter int DEB_MAX   = 1_000_000,
  parameter int ALARM_SEC = 5
) (
  input  logic               CLK,
  input  logic               RESET,
  input  logic               BTN_SS,
  input  logic               BTN_CLR,
  input  logic               BTN_MODE,
  input  logic               BTN_INC,
  input  logic               CNT_ZERO,
  output logic               CNT_EN,
  output logic               CNT_DEC,
  output logic               CNT_CLR,
  output logic               ALARM,
  output logic [STATE_W-1:0] STATE
);

  localparam int PW = (SEC1_MAX > 1) ? $clog2(SEC1_MAX) : 1;
  localparam int AW = $clog2(ALARM_SEC + 1);

  logic [NUM_BTN-1:0] press_raw;
  logic [NUM_BTN-1:0] press;
  logic               clr_p, ss_p, mode_p, inc_p;

  btn_debounce #(.DEB_MAX(DEB_MAX)) u_deb_clr  (.CLK(CLK), .RESET(RESET), .BTN(BTN_CLR),  .PRESS(press_raw[IDX_CLR]));
  btn_debounce #(.DEB_MAX(DEB_MAX)) u_deb_ss   (.CLK(CLK), .RESET(RESET), .BTN(BTN_SS),   .PRESS(press_raw[IDX_SS]));
  btn_debounce #(.DEB_MAX(DEB_MAX)) u_deb_mode (.CLK(CLK), .RESET(RESET), .BTN(BTN_MODE), .PRESS(press_raw[IDX_MODE]));
  btn_debounce #(.DEB_MAX(DEB_MAX)) u_deb_inc  (.CLK(CLK), .RESET(RESET), .BTN(BTN_INC),  .PRESS(press_raw[IDX_INC]));

  assign press  = prio_pick(press_raw);
  assign clr_p  = press[IDX_CLR];
  assign ss_p   = press[IDX_SS];
  assign mode_p = press[IDX_MODE];
  assign inc_p  = press[IDX_INC];

  state_e        state, state_nx;
  logic [PW-1:0] presc, presc_nx;
  logic [AW-1:0] asec, asec_nx;
  logic          dec_mode, dec_mode_nx;
  logic          en_nx, clr_nx, inc_fire;
  logic          presc_wrap;

  assign presc_wrap = (presc == PW'(SEC1_MAX - 1));
  assign STATE      = state;

  always_comb begin
    state_nx    = state;
    presc_nx    = presc;
    asec_nx     = asec;
    dec_mode_nx = dec_mode;
    en_nx       = 1'b0;
    clr_nx      = 1'b0;
    inc_fire    = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (clr_p) begin
          clr_nx = 1'b1;
        end else if (ss_p) begin
          // Starting a countdown that is already at 00 would alarm instantly.
          if (!(dec_mode && CNT_ZERO)) begin
            state_nx = ST_RUN;
            presc_nx = '0;
          end
        end else if (mode_p) begin
          dec_mode_nx = ~dec_mode;
        end else if (inc_p) begin
          en_nx    = 1'b1;
          inc_fire = 1'b1;
        end
      end
      ST_RUN: begin
        if (clr_p) begin
          clr_nx   = 1'b1;
          state_nx = ST_IDLE;
        end else if (ss_p) begin
          state_nx = ST_PAUSE;
        end else if (dec_mode && CNT_ZERO) begin
          state_nx = ST_ALARM;
          presc_nx = '0;
          asec_nx  = '0;
        end else begin
          presc_nx = presc_wrap ? '0 : presc + 1'b1;
          en_nx    = presc_wrap;
        end
      end
      ST_PAUSE: begin
        if (clr_p) begin
          clr_nx   = 1'b1;
          state_nx = ST_IDLE;
        end else if (ss_p) begin
          state_nx = ST_RUN;
        end
      end
      ST_ALARM: begin
        if (clr_p) begin
          clr_nx   = 1'b1;
          state_nx = ST_IDLE;
        end else if (ss_p) begin
          state_nx = ST_IDLE;
        end else begin
          presc_nx = presc_wrap ? '0 : presc + 1'b1;
          if (presc_wrap) begin
            if (asec == AW'(ALARM_SEC - 1)) state_nx = ST_IDLE;
            else                            asec_nx  = asec + 1'b1;
          end
        end
      end
      default: state_nx = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state    <= ST_IDLE;
      presc    <= '0;
      asec     <= '0;
      dec_mode <= 1'b0;
      CNT_EN   <= 1'b0;
      CNT_CLR  <= 1'b0;
      CNT_DEC  <= 1'b0;
      ALARM    <= 1'b0;
    end else begin
      state    <= state_nx;
      presc    <= presc_nx;
      asec     <= asec_nx;
      dec_mode <= dec_mode_nx;
      CNT_EN   <= en_nx;
      CNT_CLR  <= clr_nx;
      // A manual increment always steps up, whatever the selected direction.
      CNT_DEC  <= inc_fire ? 1'b0 : dec_mode_nx;
      ALARM    <= (state_nx == ST_ALARM);
    end
  end

endmodule

// File: tb/tb_cnt60_timer_ctrl.sv
// Bench for cnt60_timer_ctrl: directed scenarios plus random button traffic,
// checked every cycle against a behavioural model driving a CNT60 stand-in.
module tb_cnt60_timer_ctrl;

  localparam int SEC1_MAX  = 4;
  localparam int DEB_MAX   = 3;
  localparam int ALARM_SEC = 2;

  // ---------------- clock / reset / DUT ----------------
  logic       CLK = 1'b0;
  logic       RESET = 1'b0;
  logic       BTN_SS = 1'b0, BTN_CLR = 1'b0, BTN_MODE = 1'b0, BTN_INC = 1'b0;
  logic       CNT_ZERO;
  logic       CNT_EN, CNT_DEC, CNT_CLR, ALARM;
  logic [2:0] STATE;

  always #5 CLK = ~CLK;

  cnt60_timer_ctrl #(.SEC1_MAX(SEC1_MAX), .DEB_MAX(DEB_MAX), .ALARM_SEC(ALARM_SEC)) dut (
    .CLK(CLK), .RESET(RESET),
    .BTN_SS(BTN_SS), .BTN_CLR(BTN_CLR), .BTN_MODE(BTN_MODE), .BTN_INC(BTN_INC),
    .CNT_ZERO(CNT_ZERO),
    .CNT_EN(CNT_EN), .CNT_DEC(CNT_DEC), .CNT_CLR(CNT_CLR), .ALARM(ALARM), .STATE(STATE)
  );

  // CNT60 stand-in: 00..59 counter, not touched by RESET.
  int count = 0;
  always @(posedge CLK) begin
    if (CNT_CLR)     count <= 0;
    else if (CNT_EN) count <= CNT_DEC ? ((count == 0) ? 59 : count - 1)
                                      : ((count == 59) ? 0 : count + 1);
  end
  assign CNT_ZERO = (count == 0);

  int en_cnt = 0, clr_cnt = 0;
  always @(posedge CLK) begin
    if (CNT_EN)  en_cnt  <= en_cnt + 1;
    if (CNT_CLR) clr_cnt <= clr_cnt + 1;
  end

  // ---------------- checking ----------------
  int n_checks = 0, n_fail = 0;
  bit chk_on = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Expected vector per cycle: {state[2:0], en, dec, clr, alarm}
  logic [6:0]         exp_q[$];
  logic [DEB_MAX+1:0] m_hist[4];
  bit   [3:0]         m_lvl, m_rose, m_press;
  int                 m_st, m_phase, m_age;
  bit                 m_dec;

  function automatic void model_reset();
    for (int b = 0; b < 4; b++) m_hist[b] = '0;
    m_lvl = '0; m_rose = '0; m_press = '0;
    m_st = 0; m_phase = 0; m_age = 0; m_dec = 0;
  endfunction

  function automatic void model_step();
    bit [3:0]         raw, act;
    logic [DEB_MAX-1:0] window;
    bit               all_diff, rose_now, en, clr, inc_fire, zero;
    bit               clr_b, ss_b, mode_b, inc_b;
    int               nst;
    raw  = {BTN_INC, BTN_MODE, BTN_SS, BTN_CLR};
    zero = CNT_ZERO;
    act  = m_press;
    // A level flips once the DEB_MAX samples that left the synchronizer all disagree.
    for (int b = 0; b < 4; b++) begin
      m_hist[b] = {m_hist[b][DEB_MAX:0], raw[b]};
      window    = m_hist[b][DEB_MAX+1:2];
      all_diff  = m_lvl[b] ? (window == '0) : (&window);
      rose_now  = 0;
      if (all_diff) begin
        m_lvl[b] = !m_lvl[b];
        rose_now = m_lvl[b];
      end
      m_press[b] = m_rose[b];
      m_rose[b]  = rose_now;
    end
    clr_b  = act[0];
    ss_b   = act[1] && !act[0];
    mode_b = act[2] && !act[1] && !act[0];
    inc_b  = act[3] && (act[2:0] == 3'b000);
    en = 0; clr = 0; inc_fire = 0; nst = m_st;
    case (m_st)
      0: begin
        if (clr_b) clr = 1;
        else if (ss_b) begin
          if (!(m_dec && zero)) begin nst = 1; m_phase = 0; end
        end
        else if (mode_b) m_dec = !m_dec;
        else if (inc_b) begin en = 1; inc_fire = 1; end
      end
      1: begin
        if (clr_b) begin clr = 1; nst = 0; end
        else if (ss_b) nst = 2;
        else if (m_dec && zero) begin nst = 3; m_age = 0; end
        else begin
          m_phase++;
          if (m_phase == SEC1_MAX) begin m_phase = 0; en = 1; end
        end
      end
      2: begin
        if (clr_b) begin clr = 1; nst = 0; end
        else if (ss_b) nst = 1;
      end
      default: begin
        if (clr_b) begin clr = 1; nst = 0; end
        else if (ss_b) nst = 0;
        else begin
          m_age++;
          if (m_age == ALARM_SEC * SEC1_MAX) nst = 0;
        end
      end
    endcase
    m_st = nst;
    exp_q.push_back({3'(m_st), en, (inc_fire ? 1'b0 : m_dec), clr, (m_st == 3)});
  endfunction

  always @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      model_reset();
      exp_q.delete();
      exp_q.push_back(7'd0);
    end else begin
      model_step();
    end
  end

  always @(negedge CLK) begin
    logic [6:0] v;
    if (chk_on) chk("m_queue", exp_q.size(), 1);
    if (exp_q.size() > 0) begin
      v = exp_q.pop_front();
      if (chk_on) begin
        chk("m_state", STATE,   v[6:4]);
        chk("m_en",    CNT_EN,  v[3]);
        chk("m_dec",   CNT_DEC, v[2]);
        chk("m_clr",   CNT_CLR, v[1]);
        chk("m_alarm", ALARM,   v[0]);
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick(input int n);
    repeat (n) @(posedge CLK);
    #1;
  endtask

  task automatic drive_btns(input logic [3:0] m);
    BTN_CLR = m[0]; BTN_SS = m[1]; BTN_MODE = m[2]; BTN_INC = m[3];
  endtask

  // Returns in the first cycle after the FSM has acted on the press.
  task automatic press_btns(input logic [3:0] m);
    drive_btns(m);
    tick(DEB_MAX + 4);
    drive_btns(4'b0000);
  endtask

  task automatic press_settle(input logic [3:0] m);
    press_btns(m);
    tick(DEB_MAX + 4);
  endtask

  localparam logic [3:0] B_CLR = 4'b0001, B_SS = 4'b0010, B_MODE = 4'b0100, B_INC = 4'b1000;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    n_fail++;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // ---------------- stimulus ----------------
  initial begin
    int n, pulses, cyc, last, base;
    bit got, seen59;

    tick(3);
    RESET = 1'b1;
    chk_on = 1;
    chk("rst_state", STATE, 0);
    chk("rst_en", CNT_EN, 0);
    chk("rst_dec", CNT_DEC, 0);
    chk("rst_clr", CNT_CLR, 0);
    chk("rst_alarm", ALARM, 0);

    // Glitch shorter than DEB_MAX
    BTN_SS = 1'b1; tick(1); BTN_SS = 1'b0;
    tick(12);
    chk("glitch_state", STATE, 0);

    // Up mode: exact press latency, first step, 60-step wrap
    BTN_SS = 1'b1;
    tick(DEB_MAX + 3);
    chk("ss_lat_before", STATE, 0);
    tick(1);
    chk("ss_lat_after", STATE, 1);
    BTN_SS = 1'b0;
    n = 0; got = 0;
    for (int i = 0; i < 20 && !got; i++) begin tick(1); n++; if (CNT_EN) got = 1; end
    chk("first_en", n, 4);
    pulses = 1; cyc = 0; last = 0; seen59 = 0;
    for (int i = 0; i < 400 && pulses < 60; i++) begin
      tick(1); cyc++;
      if (count == 59) seen59 = 1;
      if (CNT_EN) begin chk("en_gap", cyc - last, 4); last = cyc; pulses++; end
    end
    chk("pulses60", pulses, 60);
    tick(1);
    chk("wrap_00", count, 0);
    chk("saw_59", seen59, 1);
    press_btns(B_SS);
    chk("pause_state", STATE, 2);
    base = en_cnt;
    tick(12);
    chk("pause_no_en", en_cnt - base, 0);

    // Down mode from 03 to alarm
    press_settle(B_CLR);
    chk("clr_idle", STATE, 0);
    chk("clr_count", count, 0);
    repeat (3) press_settle(B_INC);
    chk("inc_count", count, 3);
    press_settle(B_MODE);
    chk("mode_dec", CNT_DEC, 1);
    press_btns(B_SS);
    chk("down_run", STATE, 1);
    pulses = 0;
    for (int i = 0; i < 40 && pulses < 3; i++) begin tick(1); if (CNT_EN) pulses++; end
    chk("down_pulses", pulses, 3);
    tick(1);
    chk("zero_t1", STATE, 1);
    tick(1);
    chk("alarm_t2", STATE, 3);
    chk("alarm_on", ALARM, 1);
    n = 1;
    for (int i = 0; i < 40; i++) begin tick(1); if (!ALARM) break; n++; end
    chk("alarm_len", n, 8);
    chk("alarm_exit", STATE, 0);

    // Down mode at 00: start ignored
    base = en_cnt;
    press_settle(B_SS);
    chk("zero_ss_state", STATE, 0);
    tick(10);
    chk("zero_ss_no_en", en_cnt - base, 0);

    // CLR and SS together in RUN
    press_settle(B_MODE);
    chk("mode_up", CNT_DEC, 0);
    press_btns(B_SS);
    tick(10);
    base = clr_cnt;
    press_btns(B_CLR | B_SS);
    chk("clrss_state", STATE, 0);
    chk("clrss_pulse", CNT_CLR, 1);
    tick(6);
    chk("clrss_once", clr_cnt - base, 1);
    chk("clrss_count", count, 0);

    // Pause at prescaler phase 2, then resume
    press_btns(B_SS);
    got = 0;
    for (int i = 0; i < 10 && !got; i++) begin tick(1); if (CNT_EN) got = 1; end
    chk("ph_sync", got, 1);
    BTN_SS = 1'b1;
    tick(DEB_MAX + 4);
    BTN_SS = 1'b0;
    chk("ph2_pause", STATE, 2);
    tick(DEB_MAX + 4);
    press_btns(B_SS);
    chk("ph2_resume", STATE, 1);
    n = 0; got = 0;
    for (int i = 0; i < 10 && !got; i++) begin tick(1); n++; if (CNT_EN) got = 1; end
    chk("ph2_gap", n, 2);

    // Reset while in ALARM
    press_settle(B_CLR);
    press_settle(B_INC);
    press_settle(B_MODE);
    press_btns(B_SS);
    got = 0;
    for (int i = 0; i < 30 && !got; i++) begin tick(1); if (STATE == 3'd3) got = 1; end
    chk("reach_alarm", got, 1);
    tick(2);
    chk("alarm_pre_rst", ALARM, 1);
    #2 RESET = 1'b0;
    #1;
    chk("rst_async_alarm", ALARM, 0);
    chk("rst_async_state", STATE, 0);
    @(posedge CLK); #1 RESET = 1'b1;
    tick(2);
    chk("rst_dec_after", CNT_DEC, 0);

    // Random button traffic
    for (int it = 0; it < 60; it++) begin
      drive_btns(4'($urandom_range(1, 15)));
      tick($urandom_range(1, DEB_MAX + 6));
      drive_btns(4'b0000);
      tick($urandom_range(DEB_MAX + 3, 16));
    end
    tick(4);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
